// File: rtl/jtag_tap_controller.sv
// IEEE 1149.1 TAP controller with a 4-bit IR, 32-bit ID register, 1-bit bypass
// and a 26-bit boundary-scan shift chain; TDO and the active IR change on falling TCK.
module jtag_tap_controller #(
    parameter logic [31:0] IDCODE   = 32'h0000_0001,
    parameter int          IR_WIDTH = 4
) (
    input  logic        tck_i,
    input  logic        trst_n_i,
    input  logic        tms_i,
    input  logic        tdi_i,
    output logic        tdo_o,
    output logic        tdo_oe_o,
    input  logic [25:0] capture_data_i,
    output logic [25:0] update_data_o,
    output logic        update_o,
    output logic        ir_sample_preload_o,
    output logic        ir_extest_o,
    output logic        ir_intest_o,
    output logic        ir_clamp_o
);

    localparam logic [IR_WIDTH-1:0] OP_EXTEST  = 4'b0000;
    localparam logic [IR_WIDTH-1:0] OP_SAMPLE  = 4'b0001;
    localparam logic [IR_WIDTH-1:0] OP_INTEST  = 4'b0010;
    localparam logic [IR_WIDTH-1:0] OP_CLAMP   = 4'b0011;
    localparam logic [IR_WIDTH-1:0] OP_IDCODE  = 4'b1110;
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = 4'b0101;

    typedef enum logic [3:0] {
        ST_TLR, ST_RTI,
        ST_SEL_DR, ST_CAP_DR, ST_SHIFT_DR, ST_EXIT1_DR, ST_PAUSE_DR, ST_EXIT2_DR, ST_UPD_DR,
        ST_SEL_IR, ST_CAP_IR, ST_SHIFT_IR, ST_EXIT1_IR, ST_PAUSE_IR, ST_EXIT2_IR, ST_UPD_IR
    } tap_state_e;

    tap_state_e          state, state_next;
    logic [IR_WIDTH-1:0] ir_shift, ir_active;
    logic [25:0]         bsr;
    logic [31:0]         idr;
    logic                byp;
    logic                sel_bsr, sel_id, dr_lsb;

    // NOTE: asynchronous reset, non-blocking assignments for every flop.
    always_ff @(posedge tck_i or negedge trst_n_i) begin
        if (!trst_n_i) state <= ST_TLR;
        else           state <= state_next;
    end

    // NOTE: next state defaults to the current state so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_TLR:      state_next = tms_i ? ST_TLR      : ST_RTI;
            ST_RTI:      state_next = tms_i ? ST_SEL_DR   : ST_RTI;
            ST_SEL_DR:   state_next = tms_i ? ST_SEL_IR   : ST_CAP_DR;
            ST_CAP_DR:   state_next = tms_i ? ST_EXIT1_DR : ST_SHIFT_DR;
            ST_SHIFT_DR: state_next = tms_i ? ST_EXIT1_DR : ST_SHIFT_DR;
            ST_EXIT1_DR: state_next = tms_i ? ST_UPD_DR   : ST_PAUSE_DR;
            ST_PAUSE_DR: state_next = tms_i ? ST_EXIT2_DR : ST_PAUSE_DR;
            ST_EXIT2_DR: state_next = tms_i ? ST_UPD_DR   : ST_SHIFT_DR;
            ST_UPD_DR:   state_next = tms_i ? ST_SEL_DR   : ST_RTI;
            ST_SEL_IR:   state_next = tms_i ? ST_TLR      : ST_CAP_IR;
            ST_CAP_IR:   state_next = tms_i ? ST_EXIT1_IR : ST_SHIFT_IR;
            ST_SHIFT_IR: state_next = tms_i ? ST_EXIT1_IR : ST_SHIFT_IR;
            ST_EXIT1_IR: state_next = tms_i ? ST_UPD_IR   : ST_PAUSE_IR;
            ST_PAUSE_IR: state_next = tms_i ? ST_EXIT2_IR : ST_PAUSE_IR;
            ST_EXIT2_IR: state_next = tms_i ? ST_UPD_IR   : ST_SHIFT_IR;
            ST_UPD_IR:   state_next = tms_i ? ST_SEL_DR   : ST_RTI;
            default:     state_next = ST_TLR;
        endcase
    end

    // DR selection and the LSB of whichever register is currently on the scan path.
    always_comb begin
        sel_bsr = (ir_active == OP_EXTEST) || (ir_active == OP_SAMPLE) ||
                  (ir_active == OP_INTEST);
        sel_id  = (ir_active == OP_IDCODE);
        if (sel_bsr)     dr_lsb = bsr[0];
        else if (sel_id) dr_lsb = idr[0];
        else             dr_lsb = byp;
    end

    always_ff @(posedge tck_i or negedge trst_n_i) begin
        if (!trst_n_i) begin
            ir_shift <= IR_CAPTURE;
            bsr      <= '0;
            idr      <= IDCODE;
            byp      <= 1'b0;
        end else begin
            case (state)
                ST_CAP_IR:   ir_shift <= IR_CAPTURE;
                ST_SHIFT_IR: ir_shift <= {tdi_i, ir_shift[IR_WIDTH-1:1]};
                ST_CAP_DR: begin
                    if (sel_bsr)     bsr <= capture_data_i;
                    else if (sel_id) idr <= IDCODE;
                    else             byp <= 1'b0;
                end
                ST_SHIFT_DR: begin
                    if (sel_bsr)     bsr <= {tdi_i, bsr[25:1]};
                    else if (sel_id) idr <= {tdi_i, idr[31:1]};
                    else             byp <= tdi_i;
                end
                default: ;
            endcase
        end
    end

    // Falling-edge side: instruction update and the TDO driver.
    always_ff @(negedge tck_i or negedge trst_n_i) begin
        if (!trst_n_i) begin
            ir_active <= OP_IDCODE;
            tdo_o     <= 1'b0;
            tdo_oe_o  <= 1'b0;
        end else begin
            if (state == ST_TLR)         ir_active <= OP_IDCODE;
            else if (state == ST_UPD_IR) ir_active <= ir_shift;
            tdo_o    <= (state == ST_SHIFT_IR) ? ir_shift[0] :
                        (state == ST_SHIFT_DR) ? dr_lsb : 1'b0;
            tdo_oe_o <= (state == ST_SHIFT_IR) || (state == ST_SHIFT_DR);
        end
    end

    assign update_data_o       = bsr;
    assign update_o            = (state == ST_UPD_DR) && sel_bsr;
    assign ir_extest_o         = (ir_active == OP_EXTEST);
    assign ir_sample_preload_o = (ir_active == OP_SAMPLE);
    assign ir_intest_o         = (ir_active == OP_INTEST);
    assign ir_clamp_o          = (ir_active == OP_CLAMP);

endmodule

// File: doc/jtag_tap_controller.md
JTAG_TAP_CONTROLLER -- requirements
Module: jtag_tap_controller

Interface
REQ-001 SHALL have parameter IDCODE, default 32'h0000_0001, meaning the value loaded into the device ID register on Capture-DR; bit 0 SHALL be 1.
REQ-002 SHALL have parameter IR_WIDTH, default 4, meaning the instruction register width (fixed at 4 for this block).
REQ-003 tck_i  input  1  JTAG test clock; the block's only clock.
REQ-004 trst_n_i  input  1  reset, asynchronous, active-low.
REQ-005 tms_i  input  1  test mode select, sampled on tck_i rising edge.
REQ-006 tdi_i  input  1  test data in, sampled on tck_i rising edge.
REQ-007 tdo_o  output  1  test data out, changes on tck_i falling edge only.
REQ-008 tdo_oe_o  output  1  TDO driver enable.
REQ-009 capture_data_i  input  26  parallel boundary-scan capture value from the boundary scan register.
REQ-010 update_data_o  output  26  boundary-scan shift chain contents, presented to the boundary scan register.
REQ-011 update_o  output  1  high while the TAP is in Update-DR and the boundary-scan DR is selected.
REQ-012 ir_sample_preload_o, ir_extest_o, ir_intest_o, ir_clamp_o  output  1 each  one-hot decodes of the active instruction.

Function
REQ-013 TAP FSM SHALL implement the 16 IEEE 1149.1 states, with transitions on tck_i rising edge per tms_i: TLR, RTI, Select-DR, Capture-DR, Shift-DR, Exit1-DR, Pause-DR, Exit2-DR, Update-DR, and the same 7-state IR branch.
REQ-014 Opcodes: EXTEST 4'b0000, SAMPLE/PRELOAD 4'b0001, INTEST 4'b0010, CLAMP 4'b0011, IDCODE 4'b1110, BYPASS 4'b1111; every other code SHALL act as BYPASS.
REQ-015 IR shift stage: Capture-IR loads 4'b0101; Shift-IR shifts right with tdi_i into bit 3 and bit 0 toward TDO; Update-IR copies it to the active IR on the tck_i falling edge.
REQ-016 The active IR SHALL be forced to IDCODE while in TLR, and it SHALL not change in any other state except Update-IR.
REQ-017 DR selection: EXTEST, SAMPLE/PRELOAD and INTEST SHALL select the 26-bit boundary-scan chain; IDCODE SHALL select the 32-bit ID register; BYPASS, CLAMP and undefined codes SHALL select the 1-bit bypass.
REQ-018 Capture-DR loads the selected register: boundary from capture_data_i, ID from IDCODE, bypass with 0.
REQ-019 Shift-DR shifts the selected register right, tdi_i entering the MSB and the LSB toward TDO; unselected registers SHALL hold.
REQ-020 The boundary chain SHALL hold in every state other than Capture-DR and Shift-DR (while selected); update_data_o SHALL equal the chain contents at all times.
REQ-021 update_o SHALL be asserted combinationally during Update-DR only when the boundary chain is selected, so that a downstream falling-edge flop sees it exactly once per Update-DR.
REQ-022 tdo_o SHALL be registered on the tck_i falling edge: the IR stage LSB in Shift-IR, the selected DR LSB in Shift-DR, otherwise 0.
REQ-023 tdo_oe_o SHALL be registered on the falling edge, high exactly in Shift-IR/Shift-DR.
REQ-024 Instruction decodes SHALL come from the active IR only, never from the IR shift stage.
REQ-025 Pause-DR/Pause-IR and the Exit states SHALL preserve all shift contents, so that a scan resumed via Exit2 continues bit-exactly.

Reset
REQ-026 trst_n_i low SHALL immediately force: FSM=TLR, active IR=IDCODE, IR stage=4'b0101, boundary chain=0, ID register=IDCODE, bypass=0, tdo_o=0, tdo_oe_o=0, update_o=0, all ir_*_o=0.
REQ-027 Reset asserted mid-shift SHALL abort the scan; no update SHALL occur.
REQ-028 With trst_n_i high, five consecutive tck_i cycles with tms_i=1 SHALL reach TLR from any state.

Verification
REQ-029 Reset, go to Shift-DR, shift 32 bits -> TDO yields 32'h0000_0001 LSB first; tdo_oe_o high for exactly 32 bits.
REQ-030 Load IR=4'b0001 -> Shift-IR output reads 1,0,1,0 (LSB first); ir_sample_preload_o=1 only after the Update-IR falling edge.
REQ-031 SAMPLE/PRELOAD with capture_data_i=26'h2AA_AA55 -> 26 shifted bits read 26'h2AA_AA55 LSB first; shifting in 26'h155_55AA -> update_data_o=26'h155_55AA, and update_o is high for exactly one Update-DR state.
REQ-032 BYPASS (and opcode 4'b0111) with pattern 1,0,1,1 -> TDO shows 0,1,0,1 (one-cycle delay); update_o stays 0.
REQ-033 Shift 10 bits, go to Pause-DR for 5 cycles, resume the shift -> TDO sequence is uninterrupted and identical to a continuous shift.
REQ-034 Assert trst_n_i during Shift-DR of EXTEST -> outputs take the REQ-026 values immediately, and update_o never pulses.
